// File: rtl/ibex_compressed_encoder_pkg.sv
// rtl/ibex_compressed_encoder_pkg.sv - shared constants and packer state type
// Purpose: RV32 opcode/funct fields, compressed code constants, packer state.
// Ports: none (package).
package ibex_compressed_encoder_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;

   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_SLLI    = 3'b001;
   localparam logic [2:0] F3_ADD     = 3'b000;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;
   localparam logic [6:0] F7_ZERO    = 7'h00;

   localparam logic [31:0] INSTR_EBREAK = 32'h00100073;
   localparam logic [15:0] C_NOP        = 16'h0001;
   localparam logic [15:0] C_EBREAK     = 16'h9002;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HALF  = 1'b1
   } enc_state_e;

endpackage

// File: rtl/ibex_compressed_encoder_if.sv
// rtl/ibex_compressed_encoder_if.sv - instruction in / fetch word out bundle
// Purpose: groups the input handshake, flush, output handshake and status.
// Ports: instr_i/in_valid_i/in_ready_o (input stream), flush_i,
//        out_data_o/out_valid_o/out_ready_i (output stream), illegal_o, pending_o.
//        slave = encoder side, master = producer/consumer side.
interface ibex_compressed_encoder_if;

   logic [31:0] instr_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic        flush_i;
   logic [31:0] out_data_o;
   logic        out_valid_o;
   logic        out_ready_i;
   logic        illegal_o;
   logic        pending_o;

   modport slave (
      input  instr_i, in_valid_i, flush_i, out_ready_i,
      output in_ready_o, out_data_o, out_valid_o, illegal_o, pending_o
   );

   modport master (
      output instr_i, in_valid_i, flush_i, out_ready_i,
      input  in_ready_o, out_data_o, out_valid_o, illegal_o, pending_o
   );

endinterface

// File: rtl/ibex_compressed_encoder_comb.sv
// rtl/ibex_compressed_encoder_comb.sv - combinational RV32 to RVC compressor
// Purpose: map a 32-bit instruction to a 16-bit code when a bit-exact
//          compressed equivalent exists.
// Ports: i_instr (32-bit instruction), o_c_instr (16-bit code),
//        o_is_comp (o_c_instr is valid).
module ibex_compressed_encoder_comb
   import ibex_compressed_encoder_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [15:0] o_c_instr,
   output logic        o_is_comp
);

   logic [6:0]  w_opc;
   logic [4:0]  w_rd;
   logic [2:0]  w_f3;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [6:0]  w_f7;
   logic [11:0] w_imm_i;
   logic        w_imm6_ok;

   assign w_opc   = i_instr[6:0];
   assign w_rd    = i_instr[11:7];
   assign w_f3    = i_instr[14:12];
   assign w_rs1   = i_instr[19:15];
   assign w_rs2   = i_instr[24:20];
   assign w_f7    = i_instr[31:25];
   assign w_imm_i = i_instr[31:20];
   // imm fits a 6-bit signed field when bits [11:5] are all copies of bit 5
   assign w_imm6_ok = (i_instr[31:25] == {7{i_instr[25]}});

   always_comb begin
      o_c_instr = 16'h0000;
      o_is_comp = 1'b0;
      if (i_instr == INSTR_EBREAK) begin
         o_c_instr = C_EBREAK;
         o_is_comp = 1'b1;
      end else begin
         case (w_opc)
            OPC_OP_IMM: begin
               if (w_f3 == F3_ADDI) begin
                  if (w_rd == 5'd0 && w_rs1 == 5'd0 && w_imm_i == 12'd0) begin
                     o_c_instr = C_NOP;
                     o_is_comp = 1'b1;
                  end else if (w_rd != 5'd0 && w_rd == w_rs1 && w_imm6_ok && w_imm_i != 12'd0) begin
                     o_c_instr = {3'b000, i_instr[25], w_rd, i_instr[24:20], 2'b01};
                     o_is_comp = 1'b1;
                  end else if (w_rd != 5'd0 && w_rs1 == 5'd0 && w_imm6_ok) begin
                     o_c_instr = {3'b010, i_instr[25], w_rd, i_instr[24:20], 2'b01};
                     o_is_comp = 1'b1;
                  end
               end else if (w_f3 == F3_SLLI && w_f7 == F7_ZERO && w_rd != 5'd0 &&
                            w_rd == w_rs1 && w_rs2 != 5'd0) begin
                  o_c_instr = {3'b000, 1'b0, w_rd, w_rs2, 2'b10};
                  o_is_comp = 1'b1;
               end
            end
            OPC_OP: begin
               // rs2 == x0 would decode as C.JR/C.JALR/C.EBREAK, so exclude it
               if (w_f3 == F3_ADD && w_f7 == F7_ZERO && w_rd != 5'd0 && w_rs2 != 5'd0) begin
                  if (w_rs1 == 5'd0) begin
                     o_c_instr = {4'b1000, w_rd, w_rs2, 2'b10};
                     o_is_comp = 1'b1;
                  end else if (w_rs1 == w_rd) begin
                     o_c_instr = {4'b1001, w_rd, w_rs2, 2'b10};
                     o_is_comp = 1'b1;
                  end
               end
            end
            OPC_LOAD: begin
               // uimm[6:2] sits in instr[26:22]; bits [31:27] and [21:20] must be zero
               if (w_f3 == F3_LW && w_rd[4:3] == 2'b01 && w_rs1[4:3] == 2'b01 &&
                   i_instr[31:27] == 5'd0 && i_instr[21:20] == 2'd0) begin
                  o_c_instr = {3'b010, i_instr[25:23], w_rs1[2:0], i_instr[22],
                               i_instr[26], w_rd[2:0], 2'b00};
                  o_is_comp = 1'b1;
               end
            end
            OPC_STORE: begin
               // S-type offset {instr[31:25], instr[11:7]}: uimm[6:5]=instr[26:25], uimm[4:2]=instr[11:9]
               if (w_f3 == F3_SW && w_rs2[4:3] == 2'b01 && w_rs1[4:3] == 2'b01 &&
                   i_instr[31:27] == 5'd0 && i_instr[8:7] == 2'd0) begin
                  o_c_instr = {3'b110, i_instr[25], i_instr[11:10], w_rs1[2:0], i_instr[9],
                               i_instr[26], w_rs2[2:0], 2'b00};
                  o_is_comp = 1'b1;
               end
            end
            default: begin
               o_c_instr = 16'h0000;
               o_is_comp = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/ibex_compressed_encoder.sv
// rtl/ibex_compressed_encoder.sv - RV32 to RVC encoder with fetch-word packer
// Purpose: compress accepted instructions and pack 16/32-bit codes into
//          32-bit fetch words (lower halfword = lower address).
// Ports: clk, DEFAULT_RESET (sync, active-high), bus (slave modport:
//        input stream, flush, output stream, illegal pulse, pending flag).
module ibex_compressed_encoder
   import ibex_compressed_encoder_pkg::*;
(
   input  logic                     clk,
   input  logic                     DEFAULT_RESET,
   ibex_compressed_encoder_if.slave bus
);

   enc_state_e  r_state;
   logic [15:0] r_pend;
   logic [31:0] r_out;
   logic        r_out_valid;
   logic        r_illegal;

   logic [15:0] w_c_instr;
   logic        w_is_comp;
   logic        w_in_ready;
   logic        w_accept;
   logic        w_legal;
   logic        w_flush;

   ibex_compressed_encoder_comb u_comb (
      .i_instr   (bus.instr_i),
      .o_c_instr (w_c_instr),
      .o_is_comp (w_is_comp)
   );

   // the output register is free when empty or being drained this cycle
   assign w_in_ready = !r_out_valid || bus.out_ready_i;
   assign w_accept   = bus.in_valid_i && w_in_ready;
   assign w_legal    = (bus.instr_i[1:0] == 2'b11);
   assign w_flush    = bus.flush_i && !bus.in_valid_i && (r_state == ST_HALF) && w_in_ready;

   always_ff @(posedge clk) begin
      if (DEFAULT_RESET) begin
         r_state     <= ST_EMPTY;
         r_pend      <= 16'h0000;
         r_out       <= 32'h0000_0000;
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_illegal <= w_accept && !w_legal;
         if (r_out_valid && bus.out_ready_i) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept && w_legal) begin
            if (r_state == ST_EMPTY) begin
               if (w_is_comp) begin
                  r_pend  <= w_c_instr;
                  r_state <= ST_HALF;
               end else begin
                  r_out       <= bus.instr_i;
                  r_out_valid <= 1'b1;
               end
            end else begin
               r_out_valid <= 1'b1;
               if (w_is_comp) begin
                  r_out   <= {w_c_instr, r_pend};
                  r_state <= ST_EMPTY;
               end else begin
                  // a 32-bit instruction straddles the word: upper half stays pending
                  r_out  <= {bus.instr_i[15:0], r_pend};
                  r_pend <= bus.instr_i[31:16];
               end
            end
         end else if (w_flush) begin
            r_out       <= {C_NOP, r_pend};
            r_out_valid <= 1'b1;
            r_state     <= ST_EMPTY;
         end
      end
   end

   assign bus.in_ready_o  = w_in_ready;
   assign bus.out_data_o  = r_out;
   assign bus.out_valid_o = r_out_valid;
   assign bus.illegal_o   = r_illegal;
   assign bus.pending_o   = (r_state == ST_HALF);

endmodule

// File: tb/tb_ibex_compressed_encoder.sv
// tb/tb_ibex_compressed_encoder.sv - self-checking bench for the encoder
module tb_ibex_compressed_encoder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ibex_compressed_encoder_if u_if();

   ibex_compressed_encoder dut (
      .clk           (clk),
      .DEFAULT_RESET (rst),
      .bus           (u_if)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] instr;
      logic        comp;
      logic [15:0] code;
   } vec_t;

   localparam int N_VEC = 18;
   localparam int N_RND = 10000;
   vec_t vecs [N_VEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] instr);
      u_if.instr_i    = instr;
      u_if.in_valid_i = 1'b1;
      tick();
      u_if.in_valid_i = 1'b0;
   endtask

   function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] mk_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic logic [31:0] mk_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   // Reference RVC expansion for the subset the encoder can emit
   function automatic logic [31:0] c_expand(input logic [15:0] c);
      logic [11:0] imm;
      logic [31:0] r;
      r = 32'h0000_0000;
      case ({c[1:0], c[15:13]})
         5'b00_010: begin
            imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
            r = {imm, 2'b01, c[9:7], 3'b010, 2'b01, c[4:2], 7'h03};
         end
         5'b00_110: begin
            imm = {5'b0, c[5], c[12:10], c[6], 2'b00};
            r = {imm[11:5], 2'b01, c[4:2], 2'b01, c[9:7], 3'b010, imm[4:0], 7'h23};
         end
         5'b01_000: r = {{6{c[12]}}, c[12], c[6:2], c[11:7], 3'b000, c[11:7], 7'h13};
         5'b01_010: r = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, c[11:7], 7'h13};
         5'b10_000: r = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], 7'h13};
         5'b10_100: begin
            if (!c[12]) r = {7'b0, c[6:2], 5'd0, 3'b000, c[11:7], 7'h33};
            else if (c[11:7] == 5'd0 && c[6:2] == 5'd0) r = 32'h0010_0073;
            else r = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], 7'h33};
         end
         default: r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] gen_instr();
      int          sel;
      int          si;
      int          off;
      logic [4:0]  a;
      logic [4:0]  b;
      logic [31:0] r;
      sel = $urandom_range(0, 9);
      a   = 5'($urandom_range(0, 31));
      b   = 5'($urandom_range(0, 31));
      si  = int'($urandom_range(0, 80)) - 40;
      off = int'($urandom_range(0, 35)) * 4 + (($urandom_range(0, 7) == 0) ? 1 : 0);
      case (sel)
         0: r = mk_i(12'(si), a, 3'b000, a, 7'h13);
         1: r = mk_i(12'(si), 5'd0, 3'b000, a, 7'h13);
         2: r = mk_r(b, 5'd0, a);
         3: r = mk_r(b, a, a);
         4: r = mk_i(12'(off), 5'($urandom_range(6, 17)), 3'b010, 5'($urandom_range(6, 17)), 7'h03);
         5: r = mk_s(12'(off), 5'($urandom_range(6, 17)), 5'($urandom_range(6, 17)));
         6: r = mk_i({7'b0, b}, a, 3'b001, a, 7'h13);
         7: r = ($urandom_range(0, 1) == 0) ? 32'h0010_0073 : 32'h0000_0013;
         default: r = $urandom | 32'h3;
      endcase
      return r;
   endfunction

   logic [31:0] exp_q [$];
   logic [15:0] hw_q  [$];
   logic [31:0] dec_q [$];

   initial begin
      logic [31:0] exp_w;
      logic [31:0] w;
      logic [15:0] h;
      logic [15:0] hi;
      logic        acc;
      int          idx;
      int          cyc;
      int          ill_cnt;
      int          mism;
      int          first_bad;
      logic        drained;

      vecs[0]  = '{32'h0014_0413, 1'b1, 16'h0405};  // addi x8,x8,1
      vecs[1]  = '{32'h01F0_8093, 1'b1, 16'h00FD};  // addi x1,x1,31
      vecs[2]  = '{32'hFE00_8093, 1'b1, 16'h1081};  // addi x1,x1,-32
      vecs[3]  = '{32'h0200_8093, 1'b0, 16'h0000};  // addi x1,x1,32
      vecs[4]  = '{32'h0000_0013, 1'b1, 16'h0001};  // addi x0,x0,0
      vecs[5]  = '{32'h0050_0013, 1'b0, 16'h0000};  // addi x0,x0,5
      vecs[6]  = '{32'hFFF0_0513, 1'b1, 16'h557D};  // li x10,-1
      vecs[7]  = '{32'h0060_02B3, 1'b1, 16'h829A};  // mv x5,x6
      vecs[8]  = '{32'h0062_82B3, 1'b1, 16'h929A};  // add x5,x5,x6
      vecs[9]  = '{32'h0002_82B3, 1'b0, 16'h0000};  // add x5,x5,x0
      vecs[10] = '{32'h07C4_2483, 1'b1, 16'h5C64};  // lw x9,124(x8)
      vecs[11] = '{32'h0804_2483, 1'b0, 16'h0000};  // lw x9,128(x8)
      vecs[12] = '{32'h0004_2803, 1'b0, 16'h0000};  // lw x16,0(x8)
      vecs[13] = '{32'h0094_2223, 1'b1, 16'hC044};  // sw x9,4(x8)
      vecs[14] = '{32'h0071_9193, 1'b1, 16'h019E};  // slli x3,x3,7
      vecs[15] = '{32'h0001_9193, 1'b0, 16'h0000};  // slli x3,x3,0
      vecs[16] = '{32'h0010_0073, 1'b1, 16'h9002};  // ebreak
      vecs[17] = '{32'hDEAD_B0B7, 1'b0, 16'h0000};  // lui

      rst              = 1'b1;
      u_if.instr_i     = 32'h0;
      u_if.in_valid_i  = 1'b0;
      u_if.flush_i     = 1'b0;
      u_if.out_ready_i = 1'b1;
      repeat (3) tick();
      check("rst out_valid", {31'b0, u_if.out_valid_o}, 32'd0);
      check("rst pending",   {31'b0, u_if.pending_o},   32'd0);
      check("rst illegal",   {31'b0, u_if.illegal_o},   32'd0);
      check("rst out_data",  u_if.out_data_o,           32'd0);
      check("rst in_ready",  {31'b0, u_if.in_ready_o},  32'd1);
      rst = 1'b0;
      tick();

      // per-instruction table, each from EMPTY
      for (int i = 0; i < N_VEC; i++) begin
         send(vecs[i].instr);
         check($sformatf("vec%0d pending", i), {31'b0, u_if.pending_o}, {31'b0, vecs[i].comp});
         if (vecs[i].comp) begin
            u_if.flush_i = 1'b1;
            tick();
            u_if.flush_i = 1'b0;
            exp_w = {16'h0001, vecs[i].code};
         end else begin
            exp_w = vecs[i].instr;
         end
         check($sformatf("vec%0d valid", i), {31'b0, u_if.out_valid_o}, 32'd1);
         check($sformatf("vec%0d data", i), u_if.out_data_o, exp_w);
         check($sformatf("vec%0d empty", i), {31'b0, u_if.pending_o}, 32'd0);
         tick();
      end

      // two compressed halves pack into one word
      send(32'h0014_0413);
      check("pair pending1", {31'b0, u_if.pending_o}, 32'd1);
      check("pair novalid",  {31'b0, u_if.out_valid_o}, 32'd0);
      send(32'h0014_0413);
      check("pair valid",    {31'b0, u_if.out_valid_o}, 32'd1);
      check("pair data",     u_if.out_data_o, 32'h0405_0405);
      check("pair pending0", {31'b0, u_if.pending_o}, 32'd0);
      tick();

      // compressed then straddling 32-bit, then flush
      send(32'h0014_0413);
      send(32'hDEAD_B0B7);
      check("straddle data",    u_if.out_data_o, 32'hB0B7_0405);
      check("straddle pending", {31'b0, u_if.pending_o}, 32'd1);
      u_if.flush_i = 1'b1;
      tick();
      u_if.flush_i = 1'b0;
      check("straddle flush",   u_if.out_data_o, 32'h0001_DEAD);
      check("straddle pend0",   {31'b0, u_if.pending_o}, 32'd0);
      tick();
      check("flush empty noop", {31'b0, u_if.out_valid_o}, 32'd0);

      // flush ignored while in_valid is high
      send(32'h0010_0073);
      u_if.flush_i = 1'b1;
      send(32'h0014_0413);
      u_if.flush_i = 1'b0;
      check("flush+valid data", u_if.out_data_o, 32'h0405_9002);
      tick();

      // backpressure
      u_if.out_ready_i = 1'b0;
      send(32'hDEAD_B0B7);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp%0d data", k),  u_if.out_data_o, 32'hDEAD_B0B7);
         check($sformatf("bp%0d valid", k), {31'b0, u_if.out_valid_o}, 32'd1);
         check($sformatf("bp%0d ready", k), {31'b0, u_if.in_ready_o}, 32'd0);
         tick();
      end
      u_if.out_ready_i = 1'b1;
      #1;
      check("bp release ready", {31'b0, u_if.in_ready_o}, 32'd1);
      tick();
      check("bp drained", {31'b0, u_if.out_valid_o}, 32'd0);

      // illegal input dropped
      send(32'h0000_0001);
      check("ill pulse",   {31'b0, u_if.illegal_o}, 32'd1);
      check("ill novalid", {31'b0, u_if.out_valid_o}, 32'd0);
      check("ill nopend",  {31'b0, u_if.pending_o}, 32'd0);
      tick();
      check("ill clear",   {31'b0, u_if.illegal_o}, 32'd0);

      // reset in HALF wins over a simultaneous accept
      send(32'h0014_0413);
      check("rsthalf pend", {31'b0, u_if.pending_o}, 32'd1);
      u_if.instr_i    = 32'h0014_0413;
      u_if.in_valid_i = 1'b1;
      rst             = 1'b1;
      tick();
      u_if.in_valid_i = 1'b0;
      rst             = 1'b0;
      check("rsthalf valid", {31'b0, u_if.out_valid_o}, 32'd0);
      check("rsthalf pend0", {31'b0, u_if.pending_o}, 32'd0);
      check("rsthalf data",  u_if.out_data_o, 32'd0);
      tick();

      // random stream: unpacked and expanded output must reproduce the input
      for (int i = 0; i < N_RND; i++) exp_q.push_back(gen_instr());
      idx = 0;
      cyc = 0;
      ill_cnt = 0;
      u_if.instr_i    = exp_q[0];
      u_if.in_valid_i = ($urandom_range(0, 3) != 0);
      u_if.out_ready_i = ($urandom_range(0, 3) != 0);
      while (idx < N_RND && cyc < 60000) begin
         @(negedge clk);
         if (u_if.out_valid_o && u_if.out_ready_i) begin
            w = u_if.out_data_o;
            hw_q.push_back(w[15:0]);
            hw_q.push_back(w[31:16]);
         end
         if (u_if.illegal_o) ill_cnt++;
         acc = u_if.in_valid_i && u_if.in_ready_o;
         tick();
         cyc++;
         if (acc) idx++;
         if (idx < N_RND) begin
            u_if.instr_i    = exp_q[idx];
            u_if.in_valid_i = ($urandom_range(0, 3) != 0);
         end else begin
            u_if.in_valid_i = 1'b0;
         end
         u_if.out_ready_i = ($urandom_range(0, 3) != 0);
      end
      check("rnd all accepted", idx, N_RND);
      u_if.in_valid_i  = 1'b0;
      u_if.out_ready_i = 1'b1;
      u_if.flush_i     = 1'b1;
      drained = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (u_if.out_valid_o && u_if.out_ready_i) begin
            w = u_if.out_data_o;
            hw_q.push_back(w[15:0]);
            hw_q.push_back(w[31:16]);
         end
         if (!u_if.pending_o && !u_if.out_valid_o) begin
            drained = 1'b1;
            break;
         end
         tick();
      end
      u_if.flush_i = 1'b0;
      check("rnd drained", {31'b0, drained}, 32'd1);
      check("rnd illegal", ill_cnt, 0);

      while (hw_q.size() > 0) begin
         h = hw_q.pop_front();
         if (h[1:0] == 2'b11) begin
            if (hw_q.size() == 0) break;
            hi = hw_q.pop_front();
            dec_q.push_back({hi, h});
         end else begin
            dec_q.push_back(c_expand(h));
         end
      end
      if (dec_q.size() == N_RND + 1 && dec_q[N_RND] == 32'h0000_0013) void'(dec_q.pop_back());
      check("rnd count", dec_q.size(), N_RND);
      mism = 0;
      first_bad = -1;
      for (int i = 0; i < N_RND && i < dec_q.size(); i++) begin
         if (dec_q[i] !== exp_q[i]) begin
            if (first_bad < 0) first_bad = i;
            mism++;
         end
      end
      if (first_bad >= 0)
         $display("first stream difference at %0d: got 0x%08h expected 0x%08h",
                  first_bad, dec_q[first_bad], exp_q[first_bad]);
      check("rnd mismatches", mism, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
